spi_tx_sequencer: RTL and testbench

- Upstream feeder for the SPI master: buffers host bytes in a synchronous FIFO and hands them one at a time to the master's parallel input, using the master's ready flag for pacing.
- Captures the byte the master shifts in from MISO at the end of each transfer and presents it to the host as a one-cycle strobe.
- Sits between the host/register interface and the master's i_PDATA / i_valid / o_ready / P_DATA pins.

---
 rtl/spi_tx_sequencer_if.sv | 24 ++
 rtl/spi_tx_sequencer.sv | 157 +++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_sequencer_if.sv
// Parallel link between the transmit sequencer and the SPI master core.
// The sequencer side uses the master modport, the SPI core side the slave modport.
interface spi_tx_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pdata;     // byte presented to the SPI core (i_PDATA)
    logic             valid;     // byte presented (i_valid)
    logic             ready;     // SPI core idle (o_ready)
    logic [WIDTH-1:0] rx_pdata;  // byte shifted in from MISO (P_DATA)

    modport master (
        output pdata,
        output valid,
        input  ready,
        input  rx_pdata
    );

    modport slave (
        input  pdata,
        input  valid,
        output ready,
        output rx_pdata
    );
endinterface

// File: rtl/spi_tx_sequencer.sv
// Feeds host bytes from a small synchronous FIFO to an SPI master one at a
// time, paced by the master's ready flag, and returns each received byte to
// the host as a one-cycle strobe.
module spi_tx_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_flush,
    output logic               o_full,
    output logic               o_empty,
    output logic [AW:0]        o_level,
    spi_tx_sequencer_if.master spi,
    output logic [WIDTH-1:0]   o_rx_data,
    output logic               o_rx_valid,
    output logic               o_busy,
    output logic [15:0]        o_tx_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESENT   = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] pdata_q;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic             pop;
    logic             push;

    // Transfer sequencing: pop on IDLE->PRESENT, capture the rx byte on WAIT_DONE exit.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_count_d = tx_count_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && spi.ready) begin
                    pop     = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // The master drops ready once it has latched the byte.
                if (!spi.ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (spi.ready) begin
                    rx_data_d  = spi.rx_pdata;
                    rx_valid_d = 1'b1;
                    tx_count_d = tx_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flush abandons any transfer in flight; the last rx byte is kept.
        if (i_flush) begin
            state_d    = ST_IDLE;
            pop        = 1'b0;
            rx_valid_d = 1'b0;
            tx_count_d = 16'd0;
        end
    end

    // FIFO bookkeeping: a pop in the same cycle frees a slot, so a write at full is accepted then.
    always_comb begin
        push     = i_wr_en && (!full_q || pop) && !i_flush;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!push && pop) begin
            level_d = level_q - (AW+1)'(1);
        end
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        full_d  = (level_d == (AW+1)'(DEPTH));
        empty_d = (level_d == '0);
    end

    // FIFO storage write port; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

    // Registered read of the FIFO head straight into the byte presented to the master.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            pdata_q <= '0;
        end else if (pop) begin
            pdata_q <= mem[rd_ptr_q];
        end
    end

    // State, pointer, flag and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign spi.pdata  = pdata_q;
    assign spi.valid  = (state_q == ST_PRESENT);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_level    = level_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx_count = tx_count_q;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: an SPI master model answers each byte,
// transmitted and received bytes are checked against scoreboard queues.
module tb_spi_tx_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flush;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic [15:0] tx_count;

    spi_tx_sequencer_if #(.WIDTH(8)) spi_if ();

    spi_tx_sequencer #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_flush    (flush),
        .o_full     (full),
        .o_empty    (empty),
        .o_level    (level),
        .spi        (spi_if),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_busy     (busy),
        .o_tx_count (tx_count)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  tq[$];        // bytes expected on the master's parallel input
    logic [7:0]  rxq[$];       // bytes expected on o_rx_data
    logic [15:0] exp_count;
    logic [7:0]  last_rx;
    int          rx_seen = 0;
    logic        model_en;
    logic        idle_ready;
    int          phase;
    int          cnt;
    logic [7:0]  m_byte;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_seen < n && k < 2000) begin
            step();
            k++;
        end
        chk("rx_timeout", 32'(rx_seen >= n), 32'd1);
    endtask

    // SPI master model: ready drops one cycle after valid, stays low 16 cycles, echoes byte^0x99.
    always @(negedge clk) begin
        if (!model_en) begin
            phase        = 0;
            spi_if.ready = idle_ready;
        end else begin
            case (phase)
                0: begin
                    spi_if.ready = 1'b1;
                    if (spi_if.valid === 1'b1) begin
                        m_byte = spi_if.pdata;
                        if (tq.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                        else                chk("tx_byte", 32'(m_byte), 32'(tq.pop_front()));
                        phase = 1;
                    end
                end
                1: begin
                    chk("pdata_held", 32'(spi_if.pdata), 32'(m_byte));
                    chk("valid_held", 32'(spi_if.valid), 32'd1);
                    spi_if.ready = 1'b0;
                    cnt          = 16;
                    phase        = 2;
                end
                default: begin
                    if (cnt == 8) chk("valid_low_wait", 32'(spi_if.valid), 32'd0);
                    cnt--;
                    if (cnt == 0) begin
                        spi_if.ready    = 1'b1;
                        spi_if.rx_pdata = m_byte ^ 8'h99;
                        rxq.push_back(m_byte ^ 8'h99);
                        exp_count = exp_count + 16'd1;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Receive-side scoreboard: every strobe must match exactly one expected byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_seen++;
            if (rxq.size() == 0) begin
                chk("rx_unexpected", 32'd1, 32'd0);
            end else begin
                last_rx = rxq.pop_front();
                chk("rx_data", 32'(rx_data), 32'(last_rx));
            end
        end
    end

    initial begin
        int base;
        int k;
        int bl;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        flush      = 1'b0;
        model_en   = 1'b0;
        idle_ready = 1'b1;
        exp_count  = 16'd0;
        last_rx    = 8'h00;
        spi_if.rx_pdata = 8'h00;

        // Reset then idle
        repeat (2) step();
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(spi_if.valid), 32'd0);
        chk("rst_pdata", 32'(spi_if.pdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(tx_count), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single byte through the echo model
        model_en = 1'b1;
        step();
        tq.push_back(8'hA5);
        write_byte(8'hA5);
        chk("single_level", 32'(level), 32'd1);
        wait_rx(1);
        step();
        chk("single_rx_data", 32'(rx_data), 32'h3C);
        chk("single_count", 32'(tx_count), 32'(exp_count));
        chk("single_count_one", 32'(tx_count), 32'd1);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // Fill and overflow with the master held busy
        model_en   = 1'b0;
        idle_ready = 1'b0;
        step();
        bl = 0;
        for (int i = 1; i <= 9; i++) begin
            if (bl < 8) begin
                tq.push_back(8'(i));
                bl++;
            end
            write_byte(8'(i));
            if (i == 8) chk("fill_full_at8", 32'(full), 32'd1);
        end
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_valid", 32'(spi_if.valid), 32'd0);
        base = rx_seen;
        model_en = 1'b1;
        wait_rx(base + 8);
        step();
        chk("fill_count", 32'(tx_count), 32'(exp_count));
        chk("fill_count_nine", 32'(tx_count), 32'd9);
        chk("fill_empty", 32'(empty), 32'd1);
        chk("fill_tq_drained", 32'(tq.size()), 32'd0);

        // Simultaneous write and pop while full
        model_en   = 1'b0;
        idle_ready = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            tq.push_back(8'h10 + 8'(i));
            write_byte(8'h10 + 8'(i));
        end
        chk("sim_full_before", 32'(full), 32'd1);
        model_en = 1'b1;
        tq.push_back(8'h77);
        write_byte(8'h77);
        chk("sim_level", 32'(level), 32'd8);
        chk("sim_full", 32'(full), 32'd1);
        chk("sim_busy", 32'(busy), 32'd1);
        base = rx_seen;
        wait_rx(base + 9);
        step();
        chk("sim_empty", 32'(empty), 32'd1);
        chk("sim_last_rx", 32'(rx_data), 32'(8'h77 ^ 8'h99));
        chk("sim_count", 32'(tx_count), 32'(exp_count));

        // Flush while the first of four bytes is in WAIT_DONE
        for (int i = 0; i < 4; i++) begin
            tq.push_back(8'h21 + 8'(i));
            write_byte(8'h21 + 8'(i));
        end
        k = 0;
        while (!(busy === 1'b1 && spi_if.valid === 1'b0) && k < 200) begin
            step();
            k++;
        end
        chk("flush_reach_wait", 32'(busy === 1'b1 && spi_if.valid === 1'b0), 32'd1);
        base       = rx_seen;
        flush      = 1'b1;
        model_en   = 1'b0;
        idle_ready = 1'b1;
        tq.delete();
        step();
        flush     = 1'b0;
        exp_count = 16'd0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_valid", 32'(spi_if.valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_count", 32'(tx_count), 32'd0);
        chk("flush_rx_kept", 32'(rx_data), 32'(last_rx));
        repeat (20) step();
        chk("flush_no_rx", 32'(rx_seen), 32'(base));
        model_en = 1'b1;
        step();
        tq.push_back(8'h5A);
        write_byte(8'h5A);
        wait_rx(base + 1);
        step();
        chk("flush_new_rx", 32'(rx_data), 32'(8'h5A ^ 8'h99));
        chk("flush_new_count", 32'(tx_count), 32'd1);

        // Counter wrap from a forced 0xFFFF
        force dut.tx_count_q = 16'hFFFF;
        step();
        release dut.tx_count_q;
        exp_count = 16'hFFFF;
        step();
        base = rx_seen;
        tq.push_back(8'h81);
        write_byte(8'h81);
        wait_rx(base + 1);
        step();
        chk("wrap_count", 32'(tx_count), 32'd0);
        chk("wrap_count_model", 32'(tx_count), 32'(exp_count));
        chk("wrap_rx", 32'(rx_data), 32'(8'h81 ^ 8'h99));
        chk("end_tq_empty", 32'(tq.size()), 32'd0);
        chk("end_rxq_empty", 32'(rxq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
